// File: rtl/control_ramwrite_arbiter.sv
// rtl/control_ramwrite_arbiter.sv - round-robin owner arbiter for the framebuffer RAM write port
//
// Purpose: shares one framebuffer RAM write port among NUM_REQ command engines.
//    An owner is picked round-robin from the pending requests and keeps the port
//    until it pulses release_pulse, drops req, or the hold watchdog forces it off.
//    Between owners there is always one HANDOVER cycle with the write port gated.
//
// Ports:
//    clk               framebuffer write-side clock
//    reset             asynchronous active-low reset (0 = in reset)
//    req               per-requester level request
//    release_pulse     per-requester 1-cycle release (only the owner's bit is used)
//    in_row/in_column/in_pixel/in_data   packed requester buses, requester i at [i*W +: W]
//    in_we/in_start    per-requester write enable / access start
//    grant             one-hot owner flag
//    row/column/pixel/data_out           owner buses, 0 when no owner
//    ram_write_enable/ram_access_start   owner strobes, 0 when no owner
//    busy              port owned or in handover
//    timeout           1-cycle pulse on a watchdog-forced release
//    timeout_id        requester forced off by the last watchdog release

module control_ramwrite_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int ROW_BITS = 9,
   parameter int COL_BITS = 10,
   parameter int PIX_BITS = 2,
   parameter int MAX_HOLD = 4096
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           release_pulse,
   input  logic [NUM_REQ*ROW_BITS-1:0]  in_row,
   input  logic [NUM_REQ*COL_BITS-1:0]  in_column,
   input  logic [NUM_REQ*PIX_BITS-1:0]  in_pixel,
   input  logic [NUM_REQ*8-1:0]         in_data,
   input  logic [NUM_REQ-1:0]           in_we,
   input  logic [NUM_REQ-1:0]           in_start,
   output logic [NUM_REQ-1:0]           grant,
   output logic [ROW_BITS-1:0]          row,
   output logic [COL_BITS-1:0]          column,
   output logic [PIX_BITS-1:0]          pixel,
   output logic [7:0]                   data_out,
   output logic                         ram_write_enable,
   output logic                         ram_access_start,
   output logic                         busy,
   output logic                         timeout,
   output logic [$clog2(NUM_REQ)-1:0]   timeout_id
);

   localparam int IDW = $clog2(NUM_REQ);
   // One spare bit so the counter can reach MAX_HOLD-1 and saturate above it.
   localparam int HCW = $clog2(MAX_HOLD + 1) + 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_GRANT    = 2'd1,
      S_OWNED    = 2'd2,
      S_HANDOVER = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDW-1:0]    owner;
   logic [IDW-1:0]    rr_ptr;
   logic [HCW-1:0]    hold_cnt;
   logic              pick_found;
   logic [IDW-1:0]    pick_idx;
   logic              owner_drop;
   logic              wd_hit;
   logic              wd_force;
   logic              owning;

   // Round-robin search: first pending request at or above rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int j;
         j = (int'(rr_ptr) + k) % NUM_REQ;
         if (!pick_found && req[j]) begin
            pick_found = 1'b1;
            pick_idx   = IDW'(j);
         end
      end
   end

   assign owner_drop = release_pulse[owner] || !req[owner];
   // hold_cnt counts grant cycles from 0 in GRANT, so the grant lasts at most MAX_HOLD cycles.
   assign wd_hit     = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST);
   // A release coinciding with expiry wins: it is an ordinary handover, no timeout.
   assign wd_force   = (state == S_OWNED) && !owner_drop && wd_hit;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (pick_found) state_nxt = S_GRANT;
         S_GRANT:    state_nxt = S_OWNED;
         S_OWNED:    if (owner_drop || wd_hit) state_nxt = S_HANDOVER;
         S_HANDOVER: state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Owner, round-robin pointer, hold counter and watchdog flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner      <= '0;
         rr_ptr     <= '0;
         hold_cnt   <= '0;
         timeout    <= 1'b0;
         timeout_id <= '0;
      end else begin
         timeout <= wd_force;
         if (wd_force) begin
            timeout_id <= owner;
         end
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  owner    <= pick_idx;
                  hold_cnt <= '0;
               end
            end
            S_GRANT, S_OWNED: begin
               if (hold_cnt != {HCW{1'b1}}) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            S_HANDOVER: begin
               rr_ptr <= (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs: grant decoded from the registered state/owner; the RAM side is a
   // zero-latency mux of the owner's buses, forced to 0 whenever nobody owns the port.
   always_comb begin
      owning           = (state == S_GRANT) || (state == S_OWNED);
      busy             = (state != S_IDLE);
      grant            = '0;
      row              = '0;
      column           = '0;
      pixel            = '0;
      data_out         = '0;
      ram_write_enable = 1'b0;
      ram_access_start = 1'b0;
      if (owning) begin
         grant            = NUM_REQ'(1) << owner;
         row              = in_row[int'(owner)*ROW_BITS +: ROW_BITS];
         column           = in_column[int'(owner)*COL_BITS +: COL_BITS];
         pixel            = in_pixel[int'(owner)*PIX_BITS +: PIX_BITS];
         data_out         = in_data[int'(owner)*8 +: 8];
         ram_write_enable = in_we[owner];
         ram_access_start = in_start[owner];
      end
   end

endmodule

// File: tb/tb_control_ramwrite_arbiter.sv
// tb/tb_control_ramwrite_arbiter.sv - self-checking bench for control_ramwrite_arbiter

module tb_control_ramwrite_arbiter;

   localparam int NR = 3;
   localparam int RB = 9;
   localparam int CB = 10;
   localparam int PB = 2;
   localparam int MH = 16;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req, rel, in_we, in_start;
   logic [NR*RB-1:0] in_row;
   logic [NR*CB-1:0] in_column;
   logic [NR*PB-1:0] in_pixel;
   logic [NR*8-1:0]  in_data;
   logic [NR-1:0]   grant;
   logic [RB-1:0]   row;
   logic [CB-1:0]   column;
   logic [PB-1:0]   pixel;
   logic [7:0]      data_out;
   logic            ram_write_enable, ram_access_start, busy, timeout;
   logic [IW-1:0]   timeout_id;

   always #5 clk = ~clk;

   control_ramwrite_arbiter #(
      .NUM_REQ(NR), .ROW_BITS(RB), .COL_BITS(CB), .PIX_BITS(PB), .MAX_HOLD(MH)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .release_pulse(rel),
      .in_row(in_row), .in_column(in_column), .in_pixel(in_pixel), .in_data(in_data),
      .in_we(in_we), .in_start(in_start), .grant(grant), .row(row), .column(column),
      .pixel(pixel), .data_out(data_out), .ram_write_enable(ram_write_enable),
      .ram_access_start(ram_access_start), .busy(busy), .timeout(timeout),
      .timeout_id(timeout_id)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: who holds the port, how many grant cycles it has had,
   // whether this is the dead handover cycle, and where the next search starts.
   int m_owner = -1;
   int m_held  = 0;
   int m_ho    = 0;
   int m_ptr   = 0;
   int m_to    = 0;
   int m_to_id = 0;

   function automatic int first_from(input int ptr, input logic [NR-1:0] r);
      for (int k = 0; k < NR; k++) begin
         if (r[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic model_check();
      logic [NR-1:0] eg;
      logic [RB-1:0] er;
      logic [CB-1:0] ec;
      logic [PB-1:0] ep;
      logic [7:0]    ed;
      logic          ewe, est;
      eg = '0; er = '0; ec = '0; ep = '0; ed = '0; ewe = 1'b0; est = 1'b0;
      if (reset && m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         er  = in_row[m_owner*RB +: RB];
         ec  = in_column[m_owner*CB +: CB];
         ep  = in_pixel[m_owner*PB +: PB];
         ed  = in_data[m_owner*8 +: 8];
         ewe = in_we[m_owner];
         est = in_start[m_owner];
      end
      chk("m_grant", grant, eg);
      chk("m_busy", busy, reset && (m_owner >= 0 || m_ho != 0));
      chk("m_timeout", timeout, reset && m_to != 0);
      chk("m_timeout_id", timeout_id, reset ? m_to_id : 0);
      chk("m_row", row, er);
      chk("m_column", column, ec);
      chk("m_pixel", pixel, ep);
      chk("m_data", data_out, ed);
      chk("m_we", ram_write_enable, ewe);
      chk("m_start", ram_access_start, est);
   endtask

   task automatic model_update();
      int p;
      if (!reset) begin
         m_owner = -1; m_held = 0; m_ho = 0; m_ptr = 0; m_to = 0; m_to_id = 0;
         return;
      end
      m_to = 0;
      if (m_owner >= 0) begin
         // The first grant cycle ignores release/drop; release beats the watchdog.
         if (m_held >= 2 && (rel[m_owner] || !req[m_owner])) begin
            m_ptr = (m_owner + 1) % NR; m_owner = -1; m_ho = 1;
         end else if (m_held >= 2 && m_held >= MH) begin
            m_to = 1; m_to_id = m_owner;
            m_ptr = (m_owner + 1) % NR; m_owner = -1; m_ho = 1;
         end else begin
            m_held++;
         end
      end else if (m_ho != 0) begin
         m_ho = 0;
      end else begin
         p = first_from(m_ptr, req);
         if (p >= 0) begin
            m_owner = p; m_held = 1;
         end
      end
   endtask

   // Inputs are driven just after the rising edge; outputs checked on the falling edge.
   task automatic step();
      @(negedge clk);
      model_check();
      model_update();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   typedef struct {
      logic [2:0] req;
      logic [2:0] rel;
      logic [2:0] we;
      logic [2:0] eg;
      logic       eb;
   } vec_t;

   vec_t tbl[19];

   initial begin
      #200000;
      $display("FAIL global_time_limit cycle %0d: got running expected finished", cyc);
      $fatal(1);
   end

   initial begin
      int cnt;
      logic [RB-1:0] er;
      logic [7:0]    ed;

      tbl[0]  = '{3'b001, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[1]  = '{3'b001, 3'b000, 3'b001, 3'b001, 1'b1};
      tbl[2]  = '{3'b111, 3'b000, 3'b001, 3'b001, 1'b1};
      tbl[3]  = '{3'b111, 3'b001, 3'b000, 3'b001, 1'b1};
      tbl[4]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[5]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[6]  = '{3'b111, 3'b000, 3'b110, 3'b010, 1'b1};
      tbl[7]  = '{3'b111, 3'b100, 3'b100, 3'b010, 1'b1};
      tbl[8]  = '{3'b111, 3'b010, 3'b000, 3'b010, 1'b1};
      tbl[9]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[10] = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[11] = '{3'b111, 3'b000, 3'b100, 3'b100, 1'b1};
      tbl[12] = '{3'b111, 3'b100, 3'b000, 3'b100, 1'b1};
      tbl[13] = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[14] = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[15] = '{3'b111, 3'b000, 3'b000, 3'b001, 1'b1};
      tbl[16] = '{3'b110, 3'b000, 3'b000, 3'b001, 1'b1};
      tbl[17] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[18] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0};

      // Reset with every input active: all outputs must read 0.
      reset = 1'b0;
      req = '1; rel = '0; in_we = '1; in_start = '1;
      in_row = '1; in_column = '1; in_pixel = '1; in_data = '1;
      @(posedge clk); #1;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we", ram_write_enable, 0);
      chk("rst_row", row, 0);
      chk("rst_timeout_id", timeout_id, 0);
      step(); step();

      // Fixed buses for the table: row 5+i, data 0x10+i except requester 2 = 0xAA.
      for (int i = 0; i < NR; i++) begin
         in_row[i*RB +: RB]    = RB'(5 + i);
         in_column[i*CB +: CB] = CB'(100 + i);
         in_pixel[i*PB +: PB]  = PB'(i + 1);
         in_data[i*8 +: 8]     = (i == 2) ? 8'hAA : 8'(8'h10 + i);
      end
      req = '0; in_we = '0; in_start = '0;
      reset = 1'b1;

      for (int r = 0; r < 19; r++) begin
         req = tbl[r].req; rel = tbl[r].rel; in_we = tbl[r].we;
         in_start = ~tbl[r].we & tbl[r].req;
         #1;
         er = '0; ed = '0;
         for (int i = 0; i < NR; i++) begin
            if (tbl[r].eg[i]) begin
               er = RB'(5 + i);
               ed = (i == 2) ? 8'hAA : 8'(8'h10 + i);
            end
         end
         chk($sformatf("tbl%0d_grant", r), grant, tbl[r].eg);
         chk($sformatf("tbl%0d_busy", r), busy, tbl[r].eb);
         chk($sformatf("tbl%0d_we", r), ram_write_enable, |(tbl[r].we & tbl[r].eg));
         chk($sformatf("tbl%0d_start", r), ram_access_start, |(in_start & tbl[r].eg));
         chk($sformatf("tbl%0d_row", r), row, er);
         chk($sformatf("tbl%0d_data", r), data_out, ed);
         step();
      end
      rel = '0;

      // Owner 2 writing, then asynchronous reset between clock edges.
      req = 3'b100; in_we = 3'b100; in_start = '0;
      step();
      chk("pre_rst_grant", grant, 3'b100);
      reset = 1'b0;
      #1;
      chk("async_rst_grant", grant, 0);
      chk("async_rst_we", ram_write_enable, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_timeout", timeout, 0);
      step();
      reset = 1'b1; req = 3'b111; in_we = '0;
      cnt = 0;
      while (grant == 0 && cnt < 5) begin step(); cnt++; end
      chk("first_grant_after_rst", grant, 3'b001);

      // Owner 0 never releases: watchdog after MAX_HOLD grant cycles.
      cnt = 0;
      while (!timeout && cnt < 40) begin step(); cnt++; end
      chk("wd_cycles", cnt, MH);
      chk("wd_timeout_id", timeout_id, 0);
      chk("wd_grant", grant, 0);
      cnt = 0;
      while (grant == 0 && cnt < 5) begin step(); cnt++; end
      chk("wd_next_grant", grant, 3'b010);

      // Owner 1 releases exactly on the watchdog cycle: normal handover.
      repeat (MH - 1) step();
      rel = 3'b010;
      step();
      rel = '0;
      chk("rel_wd_timeout", timeout, 0);
      chk("rel_wd_grant", grant, 0);
      chk("rel_wd_busy", busy, 1);
      chk("rel_wd_timeout_id", timeout_id, 0);
      cnt = 0;
      while (grant == 0 && cnt < 5) begin step(); cnt++; end
      chk("rel_wd_next_grant", grant, 3'b100);

      // Lone requester re-granted after HANDOVER and IDLE.
      req = 3'b100;
      step();
      rel = 3'b100;
      step();
      rel = '0;
      cnt = 0;
      while (grant == 0 && cnt < 10) begin cnt++; step(); end
      chk("single_dead_cycles", cnt, 2);
      chk("single_regrant", grant, 3'b100);

      // Randomized traffic against the model.
      req = 3'b111;
      for (int it = 0; it < 1500; it++) begin
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
            rel[i] = ($urandom_range(0, 5) == 0);
         end
         in_we     = NR'($urandom);
         in_start  = NR'($urandom);
         in_row    = (NR*RB)'($urandom);
         in_column = (NR*CB)'($urandom);
         in_pixel  = (NR*PB)'($urandom);
         in_data   = (NR*8)'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
